// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a valid/ready request channel
// and a valid/ready response channel. Requests are serialised: one request is
// accepted, held for LATENCY wait cycles, answered, and only after the
// response is taken does the responder accept the next request.
//
// Ports
//   clk, rst            clock and synchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_we              1 = store, 0 = load
//   req_addr            byte address (must be word aligned and < 4*DEPTH)
//   req_wdata, req_be   store data and per-byte enables
//   resp_valid/ready    response handshake
//   resp_rdata          load data (0 for stores and faulted requests)
//   resp_err            misaligned or out-of-range request
module mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        lat_we_q, lat_we_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [3:0]  lat_be_q, lat_be_d;

  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  // Storage is not touched by reset; it powers up cleared.
  logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

  logic          eff_we;
  logic [31:0]   eff_addr;
  logic [31:0]   eff_wdata;
  logic [3:0]    eff_be;
  logic          eff_err;
  logic [AW-1:0] eff_idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic          enter_resp;
  logic          mem_wr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // The request that is completed on the RESP-entry edge comes straight from
  // the inputs when LATENCY=0 (entry happens on the accept edge itself) and
  // from the latched copy otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      eff_we    = req_we;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
      eff_be    = req_be;
    end else begin
      eff_we    = lat_we_q;
      eff_addr  = lat_addr_q;
      eff_wdata = lat_wdata_q;
      eff_be    = lat_be_q;
    end
    eff_err = (eff_addr[1:0] != 2'b00) || (eff_addr[31:2] >= 30'(DEPTH));
    eff_idx = eff_addr[AW+1:2];
    rd_word = mem_q[eff_idx];
    wr_word = merge_bytes(rd_word, eff_wdata, eff_be);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_we_d     = lat_we_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_be_d     = lat_be_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    enter_resp   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lat_we_d    = req_we;
          lat_addr_d  = req_addr;
          lat_wdata_d = req_wdata;
          lat_be_d    = req_be;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      resp_err_d   = eff_err;
      resp_rdata_d = (eff_err || eff_we) ? 32'h0 : rd_word;
    end
  end

  // A reset edge never commits a store, even one that would enter RESP.
  assign mem_wr = enter_resp && eff_we && !eff_err && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    lat_we_q    <= lat_we_d;
    lat_addr_q  <= lat_addr_d;
    lat_wdata_q <= lat_wdata_d;
    lat_be_q    <= lat_be_d;
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[eff_idx] <= wr_word;
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with LATENCY=2 for the
// functional sequence and one with LATENCY=0 for back-to-back throughput.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_resp_rdata;

  int checks = 0;
  int errors = 0;

  mem_responder #(.DEPTH(64), .LATENCY(2)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  mem_responder #(.DEPTH(64), .LATENCY(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_we     (b_req_we),
    .req_addr   (b_req_addr),
    .req_wdata  (b_req_wdata),
    .req_be     (b_req_be),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_rdata (b_resp_rdata),
    .resp_err   (b_resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request while idle, then count cycles until resp_valid.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output int lat);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    chk1({tag, "_ready"}, req_ready, 1'b1);
    issue(we, addr, wdata, be, lat);
    chk32({tag, "_lat"}, 32'(lat), 32'd3);
    chk32({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk1({tag, "_err"}, resp_err, exp_err);
    finish_resp();
  endtask

  initial begin
    int lat;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    req_be       = 4'h0;
    resp_ready   = 1'b0;
    b_req_valid  = 1'b0;
    b_req_we     = 1'b0;
    b_req_addr   = 32'h0;
    b_req_wdata  = 32'h0;
    b_req_be     = 4'h0;
    b_resp_ready = 1'b0;

    tick();
    tick();
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk1("rst_b_req_ready", b_req_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("post_rst_req_ready", req_ready, 1'b1);
    chk1("post_rst_b_req_ready", b_req_ready, 1'b1);

    // LATENCY=0 instance: request held high, responses taken immediately.
    b_req_valid  = 1'b1;
    b_req_we     = 1'b1;
    b_req_addr   = 32'h8;
    b_req_wdata  = 32'hCAFEF00D;
    b_req_be     = 4'hF;
    b_resp_ready = 1'b1;
    tick();
    chk1("l0_store_valid", b_resp_valid, 1'b1);
    chk32("l0_store_rdata", b_resp_rdata, 32'h0);
    chk1("l0_store_err", b_resp_err, 1'b0);
    chk1("l0_store_ready", b_req_ready, 1'b0);
    b_req_we = 1'b0;
    for (int i = 2; i <= 7; i++) begin
      tick();
      if (i % 2 == 0) begin
        chk1("l0_idle_ready", b_req_ready, 1'b1);
        chk1("l0_idle_valid", b_resp_valid, 1'b0);
      end else begin
        chk1("l0_resp_valid", b_resp_valid, 1'b1);
        chk32("l0_resp_rdata", b_resp_rdata, 32'hCAFEF00D);
        chk1("l0_resp_ready", b_req_ready, 1'b0);
      end
    end
    b_req_valid = 1'b0;
    tick();
    b_resp_ready = 1'b0;

    // LATENCY=2 instance: full store, load, partial store, be=0 no-op.
    xact("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    xact("ld_full", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
    xact("st_part", 1'b1, 32'h10, 32'h000000AA, 4'h1, 32'h0, 1'b0);
    xact("ld_part", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    xact("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    xact("ld_be0", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);

    // Faulted requests: misaligned and out of range, loads and stores.
    xact("ld_mis", 1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1);
    xact("ld_oor", 1'b0, 32'h100, 32'h0, 4'hF, 32'h0, 1'b1);
    xact("st_mis", 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    xact("st_oor", 1'b1, 32'h100, 32'h55555555, 4'hF, 32'h0, 1'b1);
    xact("ld_after_err", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);
    xact("ld_word0", 1'b0, 32'h0, 32'h0, 4'hF, 32'h0, 1'b0);

    // Response back-pressure for 5 cycles with ignored request pulses.
    issue(1'b0, 32'h10, 32'h0, 4'hF, lat);
    chk32("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid", resp_valid, 1'b1);
      chk32("bp_rdata", resp_rdata, 32'hDEADBEAA);
      chk1("bp_req_ready", req_ready, 1'b0);
      req_valid = (i % 2 == 0);
      req_we    = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h0;
      req_be    = 4'hF;
      tick();
    end
    req_valid  = 1'b0;
    req_we     = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk1("bp_after_valid", resp_valid, 1'b0);
    chk1("bp_after_ready", req_ready, 1'b1);
    xact("ld_after_bp", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);

    // Reset while in WAIT aborts the store.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    req_be    = 4'hF;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    chk1("wait_ready", req_ready, 1'b0);
    chk1("wait_valid", resp_valid, 1'b0);
    rst = 1'b1;
    tick();
    chk1("rst_wait_valid", resp_valid, 1'b0);
    chk1("rst_wait_ready", req_ready, 1'b0);
    chk32("rst_wait_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    #1;
    chk1("rst_wait_ready_after", req_ready, 1'b1);
    xact("ld_aborted", 1'b0, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
    xact("ld_keep", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEAA, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
